// File: rtl/operand_accum_pkg.sv
// ============================================================================
// Module      : operand_accum_pkg
// Description : Shared types and helpers for the operand accumulator:
//               FSM state encoding and the accumulator width function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_accum_pkg;

    // Result FSM: gathering beats, or presenting a finished result
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Width that holds COUNT per-beat sums of two n-bit operands without wrap
    function automatic int acc_width(input int n, input int count);
        return n + 1 + $clog2(count);
    endfunction

endpackage

`default_nettype wire

// File: rtl/operand_accum_stage.sv
// ============================================================================
// Module      : operand_accum_stage
// Description : One-entry input stage. Captures an accepted beat as its
//               (N+1)-bit per-beat sum and hands it to the accumulator.
//               Accept and consume may share an edge while accumulating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_accum_stage
    import operand_accum_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,        // asynchronous, active-low
    input  logic         i_valid,
    input  logic [N-1:0] i_valA,
    input  logic [N-1:0] i_valB,
    input  state_t       i_state,
    output logic         o_ready,
    output logic         o_full,
    output logic [N:0]   o_sum
);

    logic         r_full;
    logic [N:0]   r_sum;
    logic         w_accept;
    logic         w_consume;

    // The accumulator drains the stage every ACCUM edge, so a full stage
    // only blocks new beats while a result is being held
    always_comb begin
        o_ready   = !r_full || (i_state == ACCUM);
        w_accept  = i_valid && o_ready;
        w_consume = r_full && (i_state == ACCUM);
    end

    // Stage valid bit and captured per-beat sum (zero-extended, no truncation)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_sum  <= '0;
        end else begin
            if (w_accept) begin
                r_full <= 1'b1;
                r_sum  <= {1'b0, i_valA} + {1'b0, i_valB};
            end else if (w_consume) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_full = r_full;
    assign o_sum  = r_sum;

endmodule

`default_nettype wire

// File: rtl/operand_accum.sv
// ============================================================================
// Module      : operand_accum
// Description : Sums COUNT accepted beats of (IN_valA + IN_valB) and presents
//               the total on a valid/ready output. Optional running maximum
//               of the per-beat sums when OPERAND_ACCUM_MAX_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_accum
    import operand_accum_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int COUNT = 4,
    localparam int ACC_W = acc_width(N, COUNT)
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             IN_valid,
    output logic             IN_ready,
    input  logic [N-1:0]     IN_valA,
    input  logic [N-1:0]     IN_valB,
    output logic             OUT_valid,
    input  logic             OUT_ready,
    output logic [ACC_W-1:0] OUT_sum
`ifdef OPERAND_ACCUM_MAX_EN
    ,
    output logic [N:0]       OUT_max
`endif
);

    localparam int CNT_W = $clog2(COUNT + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_stage_full;
    logic [N:0]         w_beat_sum;
    logic               w_consume;
    logic               w_last;
    logic               w_release;

    operand_accum_stage #(
        .N (N)
    ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_valid (IN_valid),
        .i_valA  (IN_valA),
        .i_valB  (IN_valB),
        .i_state (r_state),
        .o_ready (IN_ready),
        .o_full  (w_stage_full),
        .o_sum   (w_beat_sum)
    );

    // Consume the staged beat in ACCUM; the final one moves us to HOLD
    always_comb begin
        w_consume = w_stage_full && (r_state == ACCUM);
        w_last    = (r_cnt == CNT_W'(COUNT - 1));
        w_release = (r_state == HOLD) && OUT_ready;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and result handshake
    always_comb begin
        w_state_nxt = r_state;
        OUT_valid   = 1'b0;
        case (r_state)
            ACCUM: begin
                if (w_consume && w_last) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                OUT_valid = 1'b1;
                if (OUT_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    // Accumulator and beat counter; cleared when the result is taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_release) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_consume) begin
            r_acc <= r_acc + {{(ACC_W - N - 1){1'b0}}, w_beat_sum};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign OUT_sum = r_acc;

`ifdef OPERAND_ACCUM_MAX_EN
    logic [N:0] r_max;

    // Running maximum of per-beat sums, updated alongside the accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_max <= '0;
        end else if (w_release) begin
            r_max <= '0;
        end else if (w_consume && (w_beat_sum > r_max)) begin
            r_max <= w_beat_sum;
        end
    end

    assign OUT_max = r_max;
`endif

endmodule

`default_nettype wire

// File: tb/tb_operand_accum.sv
// ============================================================================
// Module      : tb_operand_accum
// Description : Directed self-checking bench for operand_accum (N=4,
//               COUNT=4). OUT_max checks are active when
//               OPERAND_ACCUM_MAX_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_accum;

    localparam int N     = 4;
    localparam int COUNT = 4;
    localparam int ACC_W = 7;

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic             IN_valid  = 1'b0;
    logic             OUT_ready = 1'b0;
    logic [N-1:0]     IN_valA   = '0;
    logic [N-1:0]     IN_valB   = '0;
    logic             IN_ready;
    logic             OUT_valid;
    logic [ACC_W-1:0] OUT_sum;
`ifdef OPERAND_ACCUM_MAX_EN
    logic [N:0]       OUT_max;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    operand_accum #(
        .N     (N),
        .COUNT (COUNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .IN_valid  (IN_valid),
        .IN_ready  (IN_ready),
        .IN_valA   (IN_valA),
        .IN_valB   (IN_valB),
        .OUT_valid (OUT_valid),
        .OUT_ready (OUT_ready),
        .OUT_sum   (OUT_sum)
`ifdef OPERAND_ACCUM_MAX_EN
        ,
        .OUT_max   (OUT_max)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_max(input string tag, input int exp);
`ifdef OPERAND_ACCUM_MAX_EN
        check(tag, int'(OUT_max), exp);
`endif
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat until accepted, then idle the bus with garbage operands
    task automatic drive_beat(input logic [N-1:0] a, input logic [N-1:0] b);
        logic rdy;
        logic done;
        done     = 1'b0;
        IN_valid = 1'b1;
        IN_valA  = a;
        IN_valB  = b;
        for (int i = 0; i < 20; i++) begin
            rdy = IN_ready;
            step();
            if (rdy) begin
                done = 1'b1;
                break;
            end
        end
        check("accept_timeout", int'(done), 1);
        IN_valid = 1'b0;
        IN_valA  = 4'hF;
        IN_valB  = 4'hE;
    endtask

    // Wait (bounded) for a result, check it, then take one more edge
    task automatic wait_result(input string tag, input int exp_sum, input int exp_max);
        for (int i = 0; i < 30; i++) begin
            if (OUT_valid) break;
            step();
        end
        check({tag, "_valid"}, int'(OUT_valid), 1);
        check({tag, "_sum"}, int'(OUT_sum), exp_sum);
        check_max({tag, "_max"}, exp_max);
        step();
    endtask

    initial begin
        int accepted;
        logic rdy;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(OUT_valid), 0);
        check("rst_sum", int'(OUT_sum), 0);
        check("rst_ready", int'(IN_ready), 1);
        check_max("rst_max", 0);
        rst = 1'b1;
        step();

        // Back-to-back beats: 7+30+0+3 = 40, max 30, valid two edges after last accept
        OUT_ready = 1'b1;
        drive_beat(4'd3, 4'd4);
        drive_beat(4'd15, 4'd15);
        drive_beat(4'd0, 4'd0);
        drive_beat(4'd1, 4'd2);
        check("t1_early_valid", int'(OUT_valid), 0);
        step();
        check("t1_valid", int'(OUT_valid), 1);
        check("t1_sum", int'(OUT_sum), 40);
        check_max("t1_max", 30);
        step();
        check("t1_valid_drop", int'(OUT_valid), 0);
        check("t1_sum_clr", int'(OUT_sum), 0);
        check("t1_ready", int'(IN_ready), 1);

        // Full-scale beats: 4*30 = 120 without wrap
        for (int i = 0; i < 4; i++) drive_beat(4'd15, 4'd15);
        wait_result("t2", 120, 30);

        // Held result: one beat slips into the stage, then leads the next sum
        OUT_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive_beat(4'd1, 4'd1);
        wait_result("t3a", 8, 2);
        accepted = 0;
        IN_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            IN_valA = 4'(2 + i);
            IN_valB = 4'd3;
            rdy = IN_ready;
            step();
            if (rdy) accepted++;
            check("t3_hold_sum", int'(OUT_sum), 8);
        end
        check("t3_accepted", accepted, 1);
        check("t3_ready_low", int'(IN_ready), 0);
        check("t3_still_valid", int'(OUT_valid), 1);
        IN_valid  = 1'b0;
        OUT_ready = 1'b1;
        step();
        check("t3_release_valid", int'(OUT_valid), 0);
        check("t3_release_sum", int'(OUT_sum), 0);
        step();
        check("t3_held_first", int'(OUT_sum), 5);
        for (int i = 0; i < 3; i++) drive_beat(4'd2, 4'd2);
        wait_result("t3b", 17, 5);

        // Reset after two beats discards the partial sum (checked before any edge)
        drive_beat(4'd7, 4'd7);
        drive_beat(4'd7, 4'd7);
        step();
        #3;
        rst = 1'b0;
        #1;
        check("t4_async_sum", int'(OUT_sum), 0);
        check("t4_async_ready", int'(IN_ready), 1);
        step();
        rst = 1'b1;
        step();
        for (int i = 0; i < 4; i++) drive_beat(4'd1, 4'd1);
        wait_result("t4", 8, 2);

        // Reset while a result is held
        OUT_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive_beat(4'd3, 4'd3);
        wait_result("t4h", 24, 6);
        #3;
        rst = 1'b0;
        #1;
        check("t4h_valid", int'(OUT_valid), 0);
        check("t4h_sum", int'(OUT_sum), 0);
        step();
        rst       = 1'b1;
        OUT_ready = 1'b1;
        step();
        check("t4h_after_valid", int'(OUT_valid), 0);

        // Gapped beats with garbage on idle cycles: 7+7+6+4 = 24, max 7
        drive_beat(4'd2, 4'd5);
        step();
        drive_beat(4'd6, 4'd1);
        step();
        drive_beat(4'd3, 4'd3);
        step();
        drive_beat(4'd4, 4'd0);
        wait_result("t5", 24, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/operand_accum.md
OPERAND_ACCUM -- requirements
Module: operand_accum

Interface
REQ-001 SHALL have parameter N, default 4: operand width, matching the upstream adder stage.
REQ-002 SHALL have parameter COUNT, default 4, legal range 2..256: beats summed per result.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; asynchronous and active-low.
REQ-005 SHALL have port IN_valid, input, 1: an upstream beat is offered.
REQ-006 SHALL have port IN_ready, output, 1: the block can accept a beat.
REQ-007 SHALL have port IN_valA, input, N: first operand, fed from upstream OUT_valA.
REQ-008 SHALL have port IN_valB, input, N: second operand, fed from upstream OUT_valB.
REQ-009 SHALL have port OUT_valid, output, 1: a result is available.
REQ-010 SHALL have port OUT_ready, input, 1: the downstream consumer takes the result.
REQ-011 SHALL have port OUT_sum, output, ACC_W: accumulated result, where ACC_W = N+1+$clog2(COUNT).
REQ-012 SHALL have port OUT_max, output, N+1: largest per-beat sum in the current result; present only with OPERAND_ACCUM_MAX_EN.

Function
REQ-013 SHALL treat a beat as accepted when IN_valid and IN_ready are both high at a rising edge.
REQ-014 SHALL capture each accepted beat into a one-entry stage register and compute its per-beat sum as the zero-extended (N+1)-bit value IN_valA+IN_valB, with no truncation.
REQ-015 SHALL implement exactly two FSM states: ACCUM and HOLD.
REQ-016 SHALL, in ACCUM while the stage register is full, add the zero-extended per-beat sum into the accumulator, increment the beat counter and empty the stage register on the same edge.
REQ-017 SHALL drive IN_ready = !stage_full || (state==ACCUM), so accept and consume may occur on the same edge.
REQ-018 SHALL transition ACCUM->HOLD on the edge where the counter reaches COUNT; latency from acceptance of the last beat to OUT_valid high is 2 edges.
REQ-019 SHALL, in HOLD, drive OUT_valid high and hold OUT_sum stable; the stage register may still accept one beat, and IN_ready drops once it is full.
REQ-020 SHALL, on an OUT_valid && OUT_ready edge, clear the accumulator, counter and max, and return to ACCUM; a beat held in the stage register is summed on the following edge.
REQ-021 SHALL drive OUT_sum as don't-care-free: it equals the live accumulator in ACCUM while OUT_valid is low.
REQ-022 SHALL not wrap the accumulator, since ACC_W covers COUNT*(2^(N+1)-2).
REQ-023 SHALL ignore IN_valA and IN_valB whenever no beat is accepted.

Reset
REQ-024 SHALL, while rst is low, asynchronously force state=ACCUM, stage empty, accumulator=0, counter=0 and max=0.
REQ-025 SHALL drive reset outputs as OUT_valid=0, OUT_sum=0, OUT_max=0 and IN_ready=1.
REQ-026 SHALL discard any partial accumulation or pending result on reset, including reset mid-HOLD.

Configuration
REQ-027 SHALL use macro OPERAND_ACCUM_MAX_EN: when defined, OUT_max tracks the running maximum per-beat sum and updates on the same edge as the accumulator.
REQ-028 SHALL, when OPERAND_ACCUM_MAX_EN is undefined, omit the OUT_max port and its register, with all other behaviour identical.

Structure
REQ-029 SHALL place in package operand_accum_pkg: the state enum (ACCUM, HOLD) and an acc_width(N, COUNT) function.
REQ-030 SHALL implement the stage register with its valid bit and ready logic as sub-module operand_accum_stage.

Verification
REQ-031 SHALL cover: N=4, COUNT=4; back-to-back beats (3,4),(15,15),(0,0),(1,2) with OUT_ready=1 -> OUT_valid for 1 cycle, 2 edges after the last accept, OUT_sum=40, OUT_max=30.
REQ-032 SHALL cover: four beats of (15,15) -> OUT_sum=120 with no overflow.
REQ-033 SHALL cover: result held with OUT_ready=0 for 5 cycles while IN_valid stays high -> exactly one beat accepted, IN_ready low, OUT_sum stable; then OUT_ready pulse -> the held beat becomes the first term of the next sum.
REQ-034 SHALL cover: rst asserted low after 2 of 4 beats, then released -> the next 4 beats of (1,1) give OUT_sum=8.
REQ-035 SHALL cover: IN_valid toggled randomly with 1-cycle gaps and garbage operands on idle cycles -> the sum includes only accepted beats.
REQ-036 SHALL cover: a build without OPERAND_ACCUM_MAX_EN -> no OUT_max port exists and REQ-031 still gives OUT_sum=40.
